// File: rtl/uniq_list_ser_pkg.sv
// Shared defaults, state encoding and constants for the unique-list serializer.
// UNIQ_LIST_SER_HEADER_EN adds the HDR state for the optional count header beat.
package uniq_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [7:0] DROP_MAX = 8'hFF;

`ifdef UNIQ_LIST_SER_HEADER_EN
  typedef enum logic [1:0] {IDLE, SEND, HDR} state_e;
`else
  typedef enum logic {IDLE, SEND} state_e;
`endif

endpackage

// File: rtl/uniq_list_ser_if.sv
// Streaming word interface (valid/ready) from the serializer to a byte-wide sink.
// hdr_out exists only when UNIQ_LIST_SER_HEADER_EN is defined.
interface uniq_list_ser_if #(
  parameter int DATA_W = uniq_pkg::DATA_W,
  parameter int IDX_W  = uniq_pkg::IDX_W
);
  logic [DATA_W-1:0] data_out;
  logic              data_valid_out;
  logic              data_ready_in;
  logic [IDX_W-1:0]  data_idx_out;
  logic              data_last_out;
`ifdef UNIQ_LIST_SER_HEADER_EN
  logic              hdr_out;
`endif

  modport master (
    output data_out, data_valid_out, data_idx_out, data_last_out,
`ifdef UNIQ_LIST_SER_HEADER_EN
    output hdr_out,
`endif
    input  data_ready_in
  );

  modport slave (
    input  data_out, data_valid_out, data_idx_out, data_last_out,
`ifdef UNIQ_LIST_SER_HEADER_EN
    input  hdr_out,
`endif
    output data_ready_in
  );
endinterface

// File: rtl/uniq_valid_count.sv
// Leading-ones count from bit 0 of a per-entry valid mask (4'b1011 -> 2).
// Combinational; reusable by any consumer of the unique-value list.
module uniq_valid_count #(
  parameter int DEPTH = uniq_pkg::DEPTH,
  parameter int CNT_W = uniq_pkg::CNT_W
) (
  input  logic [DEPTH-1:0] list_valid_in,
  output logic [CNT_W-1:0] n_out
);
  logic w_run;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    n_out = '0;
    w_run = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_run && list_valid_in[k]) n_out = n_out + CNT_W'(1);
      else                            w_run = 1'b0;
    end
  end
endmodule

// File: rtl/uniq_list_ser.sv
// Snapshots the tracker's list on snap_req_in and streams valid entries, entry 0 first.
// UNIQ_LIST_SER_HEADER_EN prepends a beat carrying the entry count N.
module uniq_list_ser #(
  parameter int DATA_W = uniq_pkg::DATA_W,
  parameter int DEPTH  = uniq_pkg::DEPTH,
  parameter int IDX_W  = uniq_pkg::IDX_W
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    snap_req_in,
  input  logic [DEPTH*DATA_W-1:0] list_in,
  input  logic [DEPTH-1:0]        list_valid_in,
  uniq_list_ser_if.master         dout,
  output logic                    busy_out,
  output logic [7:0]              drop_cnt_out
);
  import uniq_pkg::*;

  localparam int N_W = $clog2(DEPTH + 1);

  state_e            r_state;
  logic [DATA_W-1:0] r_snap [DEPTH];
  logic [N_W-1:0]    r_n;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_busy;
  logic [7:0]        r_drop;
`ifdef UNIQ_LIST_SER_HEADER_EN
  logic              r_hdr;
`endif

  logic [N_W-1:0]    w_n;
  logic              w_capture;
  logic              w_drop;
  logic [IDX_W-1:0]  w_idx_nx;
  logic              w_next_last;

  uniq_valid_count #(.DEPTH(DEPTH), .CNT_W(N_W)) u_valid_count (
    .list_valid_in (list_valid_in),
    .n_out         (w_n)
  );

  assign w_capture   = (r_state == IDLE) && snap_req_in && (w_n != '0);
  // Any request outside IDLE is dropped, including one on the last-transfer edge.
  assign w_drop      = snap_req_in && ((r_state != IDLE) || (w_n == '0));
  assign w_idx_nx    = r_idx + IDX_W'(1);
  assign w_next_last = (N_W'(r_idx) + N_W'(2)) == r_n;

  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UNIQ_LIST_SER_HEADER_EN
      r_hdr   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_n    <= w_n;
            r_idx  <= '0;
            r_busy <= 1'b1;
`ifdef UNIQ_LIST_SER_HEADER_EN
            r_state <= HDR;
            r_data  <= DATA_W'(w_n);
            r_last  <= 1'b0;
            r_hdr   <= 1'b1;
`else
            r_state <= SEND;
            r_data  <= list_in[DATA_W-1:0];
            r_last  <= (w_n == N_W'(1));
`endif
          end
        end
`ifdef UNIQ_LIST_SER_HEADER_EN
        HDR: begin
          if (dout.data_ready_in) begin
            r_state <= SEND;
            r_data  <= r_snap[0];
            r_last  <= (r_n == N_W'(1));
            r_hdr   <= 1'b0;
          end
        end
`endif
        SEND: begin
          if (dout.data_ready_in) begin
            if (r_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_idx   <= '0;
            end else begin
              r_idx  <= w_idx_nx;
              r_data <= r_snap[w_idx_nx];
              r_last <= w_next_last;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: the snapshot array is reset so a fresh frame never exposes stale pre-reset data.
    if (rst_in) begin
      for (int k = 0; k < DEPTH; k++) r_snap[k] <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < DEPTH; k++) r_snap[k] <= list_in[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                           r_drop <= '0;
    else if (w_drop && r_drop != DROP_MAX) r_drop <= r_drop + 8'd1;
  end

  assign dout.data_out       = r_data;
  assign dout.data_valid_out = r_busy;
  assign dout.data_idx_out   = r_idx;
  assign dout.data_last_out  = r_last;
`ifdef UNIQ_LIST_SER_HEADER_EN
  assign dout.hdr_out        = r_hdr;
`endif
  assign busy_out            = r_busy;
  assign drop_cnt_out        = r_drop;
endmodule

// File: tb/tb_uniq_list_ser.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops on each transfer.
// Define UNIQ_LIST_SER_HEADER_EN for both RTL and bench to cover the header beat.
module tb_uniq_list_ser;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int IDX_W  = 2;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
    logic       h;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snap = 1'b0;
  logic [31:0] lst = '0;
  logic [3:0]  vld = '0;
  logic        busy;
  logic [7:0]  drop;

  beat_t exp_q[$];
  beat_t e;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_drop = 0;
  bit    mon_en = 1'b1;
  bit    stalled = 1'b0;
  logic [7:0] st_d;
  logic [1:0] st_i;

  always #5 clk = ~clk;

  uniq_list_ser_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dif ();

  uniq_list_ser #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .snap_req_in   (snap),
    .list_in       (lst),
    .list_valid_in (vld),
    .dout          (dif),
    .busy_out      (busy),
    .drop_cnt_out  (drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lead_ones(input logic [3:0] v);
    int n = 0;
    while (n < 4 && v[n]) n++;
    return n;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic bump_drop();
    if (exp_drop < 255) exp_drop++;
  endtask

  // Monitor: a beat transfers at the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (!mon_en) begin
      stalled = 1'b0;
    end else if (dif.data_valid_out) begin
      if (stalled) begin
        check("stall_data", dif.data_out, st_d);
        check("stall_idx", dif.data_idx_out, st_i);
      end
      if (dif.data_ready_in) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", dif.data_out, e.d);
          check("beat_idx", dif.data_idx_out, e.i);
          check("beat_last", dif.data_last_out, e.l);
`ifdef UNIQ_LIST_SER_HEADER_EN
          check("beat_hdr", dif.hdr_out, e.h);
`endif
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        st_d    = dif.data_out;
        st_i    = dif.data_idx_out;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Called at posedge+1; issues one request and follows the frame it should produce.
  task automatic frame(input logic [31:0] l, input logic [3:0] v, input int rmode,
                       input bit extra, input bit scramble);
    int n, beats, left, cyc;
    bit done, r;
    n     = lead_ones(v);
    beats = n;
`ifdef UNIQ_LIST_SER_HEADER_EN
    if (n > 0) begin
      exp_q.push_back('{d: 8'(n), i: 2'd0, l: 1'b0, h: 1'b1});
      beats = n + 1;
    end
`endif
    for (int k = 0; k < n; k++)
      exp_q.push_back('{d: l[k*8 +: 8], i: 2'(k), l: (k == n - 1), h: 1'b0});

    lst = l;
    vld = v;
    snap = 1'b1;
    dif.data_ready_in = ready_for(rmode, 0);
    @(posedge clk); #1;
    snap = 1'b0;
    if (n == 0) begin
      bump_drop();
      check("empty_busy", busy, 0);
      check("empty_valid", dif.data_valid_out, 0);
      check("drop_cnt", drop, exp_drop);
      return;
    end

    left = beats;
    cyc  = 1;
    done = 1'b0;
    while (!done) begin
      check("frame_busy", busy, 1);
      check("frame_valid", dif.data_valid_out, 1);
      r = ready_for(rmode, cyc);
      dif.data_ready_in = r;
      if (extra && (cyc == 2 || cyc == 3 || (r && left == 1))) begin
        snap = 1'b1;
        bump_drop();
      end
      if (scramble) lst = 32'hAAAA_AAAA ^ 32'(cyc);
      @(posedge clk); #1;
      snap = 1'b0;
      if (r) left--;
      if (left == 0) done = 1'b1;
      cyc++;
      if (cyc > 64) begin
        check("frame_timeout", 1, 0);
        done = 1'b1;
      end
    end
    check("end_busy", busy, 0);
    check("end_valid", dif.data_valid_out, 0);
    check("drop_cnt", drop, exp_drop);
  endtask

  initial begin
    dif.data_ready_in = 1'b0;
    #12;
    check("rst_valid", dif.data_valid_out, 0);
    check("rst_last", dif.data_last_out, 0);
    check("rst_busy", busy, 0);
    check("rst_data", dif.data_out, 0);
    check("rst_idx", dif.data_idx_out, 0);
    check("rst_drop", drop, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Full frame, back-pressure, empty and broken-thermometer masks.
    frame(32'h4433_2211, 4'b1111, 0, 1'b0, 1'b0);
    frame(32'h4433_2211, 4'b0011, 1, 1'b0, 1'b0);
    frame(32'h4433_2211, 4'b0000, 0, 1'b0, 1'b0);
    frame(32'h4433_2211, 4'b1101, 0, 1'b0, 1'b0);
    frame(32'h4433_2211, 4'b0111, 0, 1'b0, 1'b0);
    // In-frame drops (two mid-frame, one on the last-transfer edge) with list_in scrambled.
    frame(32'h4433_2211, 4'b1111, 0, 1'b1, 1'b1);

    for (int t = 0; t < 24; t++)
      frame($urandom, 4'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));

    for (int t = 0; t < 300; t++) frame($urandom, 4'b0000, 0, 1'b0, 1'b0);
    check("drop_saturated", drop, 255);

    // Asynchronous reset in the middle of a frame.
    mon_en = 1'b0;
    lst = 32'h4433_2211;
    vld = 4'b1111;
    dif.data_ready_in = 1'b1;
    snap = 1'b1;
    @(posedge clk); #1;
    snap = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_idx", dif.data_idx_out, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", dif.data_valid_out, 0);
    check("arst_busy", busy, 0);
    check("arst_data", dif.data_out, 0);
    check("arst_idx", dif.data_idx_out, 0);
    check("arst_last", dif.data_last_out, 0);
    check("arst_drop", drop, 0);
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);
    mon_en = 1'b1;
    frame(32'h8877_6655, 4'b1111, 0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
